// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions used by the transmitter (and intended for the
//   matching receiver):
//     - state_t       : frame FSM state encoding
//     - CNT_W         : width of the bit-period counter
//     - BIT_IDX_W     : width of the data bit index
//     - clks_per_bit(): clock cycles per serial bit (integer division)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int CNT_W     = 16;
    localparam int BIT_IDX_W = 3;

    function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Single-clock synchronous FIFO buffering bytes waiting to be serialised.
//   Push is ignored when full, pop is ignored when empty. A simultaneous push
//   and pop leaves the occupancy unchanged. Head entry is always visible on
//   pop_data (first-word fall-through).
//
//   Ports:
//     clk       in   clock, rising edge
//     rst_n     in   synchronous active-low reset (pointers and count only)
//     push      in   write push_data this cycle (if not full)
//     push_data in   WIDTH-bit entry to write
//     pop       in   discard head entry this cycle (if not empty)
//     pop_data  out  current head entry
//     full      out  no free entries
//     empty     out  no stored entries
//     count     out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   FIFO-buffered UART transmitter, 8N1 framing (start 0, 8 data bits LSB
//   first, stop 1), each bit held CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE clocks.
//   Frames are sent back to back while the FIFO holds data.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> even parity bit (XOR of the data bits) between the last
//                  data bit and the stop bit, 11 bit-periods per frame
//     undefined -> 10 bit-periods per frame, no parity logic
//
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   synchronous active-low reset; aborts any frame and
//                     empties the FIFO
//     tx_data    in   byte to send
//     tx_valid   in   tx_data valid; accepted when tx_ready is high
//     tx_ready   out  FIFO not full
//     tx         out  registered serial line, idle high
//     tx_busy    out  FSM not in IDLE
//     fifo_count out  FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST = '1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [7:0] fifo_head;
    logic       bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign tx_busy  = (state_q != IDLE);
    assign tx       = tx_q;
    assign bit_end  = (cnt_q == CNT_LAST);

    // tx_d is decoded from the current state, so the line lags the state by
    // one clock. Every bit is delayed equally, so bit widths are exact and the
    // line falls two edges after a byte lands in an idle, empty FIFO.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!fifo_empty) begin
                    state_d  = START;
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
`ifdef UART_TX_PARITY_EN
                    par_d    = ^fifo_head;
`endif
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    cnt_d     = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = par_q;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // Chain straight into the next start bit when data is
                    // waiting, so frames leave with no idle gap.
                    if (!fifo_empty) begin
                        state_d  = START;
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
`ifdef UART_TX_PARITY_EN
                        par_d    = ^fifo_head;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // Unreachable encodings (including PARITY when the feature
                // is compiled out) recover to IDLE with the line high.
                state_d   = IDLE;
                cnt_d     = '0;
                bit_idx_d = '0;
                tx_d      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule
